// File: rtl/fifo_stream_pkg.sv
// Shared constants and pointer helper for the FIFO read-side stream adapter.
package fifo_stream_pkg;

  localparam int FRS_BUF_DEPTH = 3;
  localparam int FRS_PTR_W     = 2;
  localparam int FRS_LVL_W     = 2;

  // Circular increment over the FRS_BUF_DEPTH buffer slots.
  function automatic logic [FRS_PTR_W-1:0] frs_ptr_inc(input logic [FRS_PTR_W-1:0] ptr);
    logic [FRS_PTR_W-1:0] nxt;
    if (ptr == FRS_PTR_W'(FRS_BUF_DEPTH - 1)) begin
      nxt = {FRS_PTR_W{1'b0}};
    end else begin
      nxt = ptr + FRS_PTR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stream_buf3.sv
// Three-entry in-order buffer with push/pop and occupancy; head entry is
// presented combinationally from registered storage.
module stream_buf3
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [FRS_LVL_W-1:0]  level
);

  logic [DATA_WIDTH-1:0] mem_r [FRS_BUF_DEPTH];
  logic [FRS_PTR_W-1:0]  head_r;
  logic [FRS_PTR_W-1:0]  tail_r;
  logic [FRS_LVL_W-1:0]  level_r;

  // Storage, pointers and occupancy advance on push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r   <= '{default: '0};
      head_r  <= {FRS_PTR_W{1'b0}};
      tail_r  <= {FRS_PTR_W{1'b0}};
      level_r <= {FRS_LVL_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[tail_r] <= push_data;
        tail_r        <= frs_ptr_inc(tail_r);
      end
      if (pop) begin
        head_r <= frs_ptr_inc(head_r);
      end
      case ({push, pop})
        2'b10:   level_r <= level_r + FRS_LVL_W'(1);
        2'b01:   level_r <= level_r - FRS_LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Head slot select.
  always_comb begin
    head_data = {DATA_WIDTH{1'b0}};
    case (head_r)
      2'd0:    head_data = mem_r[0];
      2'd1:    head_data = mem_r[1];
      2'd2:    head_data = mem_r[2];
      default: head_data = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign level = level_r;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains an async FIFO read port into a valid/ready stream through a 3-entry
// prefetch buffer. Define FIFO_RD_STREAM_LAST_EN to generate m_last every PKT_LEN beats.
module fifo_rd_stream
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [1:0]            buf_level
);

  localparam int CRD_W = FRS_LVL_W + 1;

  logic                 pending_r;
  logic [FRS_LVL_W-1:0] level_s;
  logic [CRD_W-1:0]     credit_s;
  logic                 rd_en_s;
  logic                 m_valid_s;
  logic                 pop_s;

  // Reads are issued only while buffered plus in-flight words leave a free slot,
  // so the capture can never overflow and m_ready never reaches the read strobe.
  always_comb begin
    credit_s = {1'b0, level_s} + {{FRS_LVL_W{1'b0}}, pending_r};
    rd_en_s  = 1'b0;
    if (enable && !fifo_empty && (credit_s < CRD_W'(FRS_BUF_DEPTH))) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // FIFO read data arrives one cycle after an accepted read.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= rd_en_s;
    end
  end

  assign m_valid_s = (level_s != {FRS_LVL_W{1'b0}});
  assign pop_s     = m_valid_s && m_ready;

  stream_buf3 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (pending_r),
    .push_data (fifo_rd_data),
    .pop       (pop_s),
    .head_data (m_data),
    .level     (level_s)
  );

  assign fifo_rd_en = rd_en_s;
  assign m_valid    = m_valid_s;
  assign buf_level  = level_s;

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN - 1);

  logic [CNT_W-1:0] beat_r;

  // Beat position within the packet; only reset clears it.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      beat_r <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      beat_r <= (beat_r == LAST_BEAT) ? {CNT_W{1'b0}} : beat_r + CNT_W'(1);
    end else begin
      beat_r <= beat_r;
    end
  end

  assign m_last = m_valid_s && (beat_r == LAST_BEAT);
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side adapter that drains an asynchronous FIFO's read port and presents the words as a valid/ready stream. It sits directly downstream of the async FIFO, in the read clock domain. It hides the FIFO's one-cycle read latency behind a small prefetch buffer, so a consumer that holds ready high receives one word per cycle.

## Interface
- `DATA_WIDTH`, 32, word width; must match the FIFO.
- `PKT_LEN`, 16, beats per packet for `m_last` generation; valid range ≥ 1; used only with `FIFO_RD_STREAM_LAST_EN`.
- `rd_clk`  in  1  read-domain clock, the same clock as the FIFO read side.
- `rd_rst`  in  1  asynchronous, active-high reset. Assertion must coincide with the FIFO read-side reset.
- `enable`  in  1  when low, no new FIFO reads are issued; buffered words still drain.
- `fifo_empty`  in  1  FIFO empty flag, combinational in the FIFO.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted read.
- `m_valid`  out  1  stream word available.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DATA_WIDTH  stream word.
- `m_last`  out  1  final beat of a packet; constant 0 without the macro.
- `buf_level`  out  2  number of words held in the output buffer (0..3).

## Operation
- **Read issue**
  - Accepted read = `fifo_rd_en && !fifo_empty`.
  - `fifo_rd_en = enable && !fifo_empty && (level + pending) < 3`.
  - `level` is the number of registered buffer entries (0..3).
  - `pending` is a 1-bit flag, set for the cycle following an accepted read.
  - `fifo_rd_en` is never asserted while `fifo_empty` is high.
  - There is no combinational path from `m_ready` to `fifo_rd_en`.
- **Capture**
  - While `pending` = 1, `fifo_rd_data` is written into the buffer tail at the next edge.
  - The credit rule guarantees that a free slot exists; overflow is impossible by construction.
- **Buffer**
  - 3-entry in-order FIFO (circular, 2-bit head/tail).
  - `m_data` is taken from the head entry; `m_valid = (level != 0)`.
- **Pop**
  - A handshake is `m_valid && m_ready`; it advances the head.
  - Push and pop in the same cycle leave `level` unchanged.
  - `m_data` and `m_valid` remain stable while `m_valid && !m_ready`.
- **Disable**
  - Dropping `enable` stops issue the same cycle.
  - An already-pending word is still captured; no word is lost or duplicated.
- **Outputs at reset**
  - `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0, `m_last` = 0, `buf_level` = 0, `pending` = 0.
  - The beat counter is 0.
- **Reset mid-operation**
  - All buffered and pending words are discarded.
  - Stream restarts from the FIFO's reset state.

## Timing
- **Latency:** accepted read in cycle N → word at the buffer in cycle N+2 (`m_valid` high in N+2 if the buffer was empty).
- **Empty edge:** FIFO non-empty, buffer empty, `enable` = 1 → `fifo_rd_en` is high in the same cycle `fifo_empty` falls.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, steady state is `level` = 1, `pending` = 1, one read and one handshake per cycle.
- **Backpressure:** with `m_ready` held low, issue stops once `level + pending` = 3; at most 3 words are held.
- **Resume:** `m_ready` rising with `level` = 3 → reads resume the next cycle; there is no bubble at the output.

## Configuration
- `FIFO_RD_STREAM_LAST_EN` defined:
  - The beat counter (0..`PKT_LEN`-1) increments on each handshake and wraps to 0 after `PKT_LEN`-1.
  - `m_last = m_valid && (count == PKT_LEN-1)`.
  - `PKT_LEN` = 1 gives `m_last` on every beat.
  - The counter is cleared only by reset, not by `enable`.
- Undefined: no counter is generated; `m_last` is tied to 0. Port list is identical.

## Structure
- Shared package `fifo_stream_pkg`:
  - `FRS_BUF_DEPTH` = 3.
  - `FRS_PTR_W` = 2.
  - `FRS_LVL_W` = 2.
- One sub-module, `stream_buf3`: the 3-entry synchronous buffer with push/pop/level. The top level holds issue/credit logic, the pending flag and the beat counter.

## Test plan
- **Burst, ready high:** preload the FIFO with 0x00..0x07, `m_ready` = 1 → `m_data` 0x00..0x07 on 8 consecutive cycles, first `m_valid` 2 cycles after the first `fifo_rd_en`.
- **Backpressure:** preload 6 words, `m_ready` = 0 → `buf_level` = 3, `fifo_rd_en` held 0. Then `m_ready` = 1 → all 6 words delivered in order, no gap.
- **Random `m_ready` toggling:** 1000 random words and random `fifo_empty` gaps → output sequence equals input; `fifo_rd_en && fifo_empty` never seen; `level` never exceeds 3.
- **Enable drop:** deassert `enable` on the cycle of a read → that one pending word still appears; no further reads until `enable` returns.
- **Reset mid-stream:** assert `rd_rst` with `level` = 2 → `m_valid`, `buf_level` and `m_last` are 0 immediately (async); after release, normal operation.
- **With `FIFO_RD_STREAM_LAST_EN`, `PKT_LEN` = 4:** stream 12 words → `m_last` on beats 3, 7 and 11 only, including stalls on the last beat.
